// File: rtl/spi_reg_fifo.sv
// SPI register-file front end: byte-strobed control registers, TX/RX FIFOs,
// sticky W1C events, maskable level interrupt and a registered read port.
module spi_reg_fifo #(
  parameter int         C_S_AXI_DATA_WIDTH = 32,
  parameter int         C_S_AXI_ADDR_WIDTH = 12,
  parameter logic [3:0] C_SPI_BASE         = 4'h0,
  parameter int         TXF_DEPTH          = 8,
  parameter int         RXF_DEPTH          = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          spi_reg_wren,
  input  logic                          spi_reg_rden,
  output logic [C_S_AXI_DATA_WIDTH-1:0] spi_reg_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] spmode,
  output logic [C_S_AXI_DATA_WIDTH-1:0] spcom,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] rx_data,
  input  logic                          rx_valid,
  input  logic                          spi_done,
  output logic                          spi_irq
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int TPW = $clog2(TXF_DEPTH);
  localparam int RPW = $clog2(RXF_DEPTH);
  localparam logic [TPW:0] TX_FULL = (TPW+1)'(TXF_DEPTH);
  localparam logic [RPW:0] RX_FULL = (RPW+1)'(RXF_DEPTH);

  logic [DW-1:0]  spmode_q, spmode_d, spim_q, spim_d, spcom_q, spcom_d;
  logic [DW-1:0]  rdata_q, rdata_d, rd_mux, wmask, spie_val;
  logic           don_q, don_d, rxovf_q, rxovf_d, txovf_q, txovf_d, irq_q, irq_d;
  logic [DW-1:0]  tx_mem_q [TXF_DEPTH];
  logic [DW-1:0]  rx_mem_q [RXF_DEPTH];
  logic [TPW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [RPW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [TPW:0]   tx_cnt_q, tx_cnt_d;
  logic [RPW:0]   rx_cnt_q, rx_cnt_d;

  logic       wr_hit, rd_hit;
  logic [5:0] wr_word, rd_word;
  logic       wr_spmode, wr_spie, wr_spim, wr_spcom, wr_spitf;
  logic       tx_full, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic       unused_addr_bits;

  assign wr_hit    = spi_reg_wren && (S_AXI_AWADDR[11:8] == C_SPI_BASE);
  assign rd_hit    = spi_reg_rden && (S_AXI_ARADDR[11:8] == C_SPI_BASE);
  assign wr_word   = S_AXI_AWADDR[7:2];
  assign rd_word   = S_AXI_ARADDR[7:2];
  assign wr_spmode = wr_hit && (wr_word == 6'h0);
  assign wr_spie   = wr_hit && (wr_word == 6'h1);
  assign wr_spim   = wr_hit && (wr_word == 6'h2);
  assign wr_spcom  = wr_hit && (wr_word == 6'h3);
  assign wr_spitf  = wr_hit && (wr_word == 6'h4) && (S_AXI_WSTRB != 4'b0000);
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
  end

  assign spmode_d = wr_spmode ? ((spmode_q & ~wmask) | (S_AXI_WDATA & wmask)) : spmode_q;
  assign spim_d   = wr_spim   ? ((spim_q   & ~wmask) | (S_AXI_WDATA & wmask)) : spim_q;
  assign spcom_d  = wr_spcom  ? ((spcom_q  & ~wmask) | (S_AXI_WDATA & wmask)) : spcom_q;

  // Full/empty come from the registered counts, so a push at full is dropped
  // even when the same cycle pops.
  assign tx_full  = (tx_cnt_q == TX_FULL);
  assign rx_full  = (rx_cnt_q == RX_FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_valid = (tx_cnt_q != '0);
  assign tx_push  = wr_spitf && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd_hit && (rd_word == 6'h5) && !rx_empty;
  assign tx_cnt_d = tx_cnt_q + (TPW+1)'(tx_push) - (TPW+1)'(tx_pop);
  assign rx_cnt_d = rx_cnt_q + (RPW+1)'(rx_push) - (RPW+1)'(rx_pop);

  // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C.
  assign don_d   = (don_q   & ~(wr_spie & S_AXI_WDATA[0])) | spi_done;
  assign rxovf_d = (rxovf_q & ~(wr_spie & S_AXI_WDATA[1])) | (rx_valid && rx_full);
  assign txovf_d = (txovf_q & ~(wr_spie & S_AXI_WDATA[2])) | (wr_spitf && tx_full);
  assign spie_val = DW'({!tx_full, !rx_empty, txovf_q, rxovf_q, don_q});
  assign irq_d    = |(spie_val & spim_q);

  always_comb begin
    rd_mux = '0;
    if (rd_hit) begin
      case (rd_word)
        6'h0:    rd_mux = spmode_q;
        6'h1:    rd_mux = spie_val;
        6'h2:    rd_mux = spim_q;
        6'h3:    rd_mux = spcom_q;
        6'h5:    rd_mux = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
        6'h6:    rd_mux = DW'({8'(rx_cnt_q), 8'(tx_cnt_q)});
        default: rd_mux = '0;
      endcase
    end
  end
  assign rdata_d = spi_reg_rden ? rd_mux : rdata_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      spmode_q    <= '0;
      spim_q      <= '0;
      spcom_q     <= '0;
      rdata_q     <= '0;
      don_q       <= 1'b0;
      rxovf_q     <= 1'b0;
      txovf_q     <= 1'b0;
      irq_q       <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      spmode_q <= spmode_d;
      spim_q   <= spim_d;
      spcom_q  <= spcom_d;
      rdata_q  <= rdata_d;
      don_q    <= don_d;
      rxovf_q  <= rxovf_d;
      txovf_q  <= txovf_d;
      irq_q    <= irq_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TPW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TPW'(1);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RPW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RPW'(1);
    end
  end

  // FIFO storage carries no reset; every read of it is gated by a count.
  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= S_AXI_WDATA;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
  end

  assign tx_data      = tx_valid ? tx_mem_q[tx_rd_ptr_q] : '0;
  assign spmode       = spmode_q;
  assign spcom        = spcom_q;
  assign spi_irq      = irq_q;
  assign spi_reg_data = rdata_q;
endmodule

// File: tb/tb_spi_reg_fifo.sv
// Testbench for spi_reg_fifo: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_spi_reg_fifo;
  localparam int DEPTH = 8;
  localparam logic [11:0] A_SPMODE = 12'h000, A_SPIE = 12'h004, A_SPIM = 12'h008,
                          A_SPCOM = 12'h00C, A_SPITF = 12'h010, A_SPIRF = 12'h014,
                          A_SPFIFO = 12'h018;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rx_data = '0;
  logic [3:0]  wstrb = '0;
  logic        wren = 1'b0, rden = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0, spi_done = 1'b0;
  logic [31:0] spi_reg_data, spmode, spcom, tx_data;
  logic        tx_valid, spi_irq;

  int n_checks = 0;
  int n_pass = 0;

  spi_reg_fifo #(.TXF_DEPTH(DEPTH), .RXF_DEPTH(DEPTH)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .S_AXI_AWADDR(awaddr), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_ARADDR(araddr), .spi_reg_wren(wren), .spi_reg_rden(rden),
    .spi_reg_data(spi_reg_data), .spmode(spmode), .spcom(spcom), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .spi_done(spi_done), .spi_irq(spi_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; wren = 1'b0; rden = 1'b0; wstrb = '0; tx_ready = 1'b0;
    rx_valid = 1'b0; spi_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; wren = 1'b1;
    tick();
    wren = 1'b0; wstrb = '0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    araddr = a; rden = 1'b1;
    tick();
    rden = 1'b0;
    chk(name, spi_reg_data, exp);
  endtask

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[14];

  // Reference model state
  logic [31:0] m_spmode, m_spim, m_spcom, m_rdata;
  bit          m_don, m_rxovf, m_txovf;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];

  function automatic logic [31:0] m_spie();
    return {27'b0, txq.size() != DEPTH, rxq.size() != 0, m_txovf, m_rxovf, m_don};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [11:0] pick_addr();
    int r = $urandom_range(0, 9);
    if (r < 8) return {4'h0, 6'(r), 2'b00};
    if (r == 8) return {4'h1, 6'($urandom_range(0, 7)), 2'b00};
    return {4'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    logic irq_exp, set_tx, set_rx, wr_pg;
    int   tx_pre, rx_pre;
    logic [5:0] w;

    do_reset();
    chk("rst_rdata", spi_reg_data, 0);
    chk("rst_spmode", spmode, 0);
    chk("rst_spcom", spcom, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_txvalid", 32'(tx_valid), 0);
    chk("rst_irq", 32'(spi_irq), 0);

    vt[0]  = '{1'b1, A_SPMODE, 32'hAABBCCDD, 4'b0101, 32'h0, "wr_spmode"};
    vt[1]  = '{1'b0, A_SPMODE, 32'h0, 4'h0, 32'h00BB00DD, "spmode_strb"};
    vt[2]  = '{1'b1, A_SPCOM, 32'h12345678, 4'hF, 32'h0, "wr_spcom"};
    vt[3]  = '{1'b0, A_SPCOM, 32'h0, 4'h0, 32'h12345678, "spcom_full"};
    vt[4]  = '{1'b1, A_SPCOM, 32'hFFFFFFFF, 4'b1000, 32'h0, "wr_spcom_b3"};
    vt[5]  = '{1'b0, A_SPCOM, 32'h0, 4'h0, 32'hFF345678, "spcom_b3"};
    vt[6]  = '{1'b0, A_SPIE, 32'h0, 4'h0, 32'h00000010, "spie_idle"};
    vt[7]  = '{1'b0, A_SPFIFO, 32'h0, 4'h0, 32'h0, "spfifo_idle"};
    vt[8]  = '{1'b0, 12'h01C, 32'h0, 4'h0, 32'h0, "unmapped_rd"};
    vt[9]  = '{1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 32'h0, "wr_miss"};
    vt[10] = '{1'b0, A_SPMODE, 32'h0, 4'h0, 32'h00BB00DD, "spmode_after_miss"};
    vt[11] = '{1'b0, 12'h100, 32'h0, 4'h0, 32'h0, "rd_miss"};
    vt[12] = '{1'b1, A_SPIM, 32'h0, 4'hF, 32'h0, "wr_spim"};
    vt[13] = '{1'b0, A_SPIM, 32'h0, 4'h0, 32'h0, "spim_zero"};
    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].data, vt[i].strb);
      else rd_chk(vt[i].name, vt[i].addr, vt[i].exp);
    end
    chk("spmode_out", spmode, 32'h00BB00DD);
    chk("spcom_out", spcom, 32'hFF345678);

    // TX overflow then drain in order
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(A_SPITF, 32'(i), 4'hF);
    rd_chk("tx_cnt_full", A_SPFIFO, 32'h8);
    rd_chk("spie_txovf", A_SPIE, 32'h4);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("tx_valid_drain", 32'(tx_valid), 1);
      chk("tx_data_drain", tx_data, 32'(k));
      tick();
    end
    chk("tx_valid_empty", 32'(tx_valid), 0);
    tx_ready = 1'b0;
    wr(A_SPIE, 32'h4, 4'hF);
    rd_chk("spie_txovf_clr", A_SPIE, 32'h10);

    // RX order, empty read
    rx_valid = 1'b1; rx_data = 32'h11; tick();
    rx_data = 32'h22; tick();
    rx_valid = 1'b0;
    rd_chk("rx_cnt2", A_SPFIFO, 32'h0200);
    rd_chk("rx_pop1", A_SPIRF, 32'h11);
    rd_chk("rx_pop2", A_SPIRF, 32'h22);
    rd_chk("rx_pop_empty", A_SPIRF, 32'h0);
    rd_chk("spie_rx_empty", A_SPIE, 32'h10);

    // RX overflow, page-miss read does not pop
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin rx_data = 32'hA0 + 32'(i); tick(); end
    rx_valid = 1'b0;
    rd_chk("spie_rxovf", A_SPIE, 32'h1A);
    rd_chk("rd_miss_rx", 12'h114, 32'h0);
    rd_chk("rx_cnt_full", A_SPFIFO, 32'h0800);
    for (int i = 0; i < 8; i++) rd_chk("rx_drain", A_SPIRF, 32'hA0 + 32'(i));
    wr(A_SPIE, 32'h2, 4'hF);
    rd_chk("spie_rxovf_clr", A_SPIE, 32'h10);

    // Interrupt latency, W1C, set-wins
    wr(A_SPIM, 32'h1, 4'hF);
    spi_done = 1'b1; tick(); spi_done = 1'b0;
    chk("irq_n", 32'(spi_irq), 0);
    tick();
    chk("irq_n1", 32'(spi_irq), 1);
    wr(A_SPIE, 32'h1, 4'hF);
    chk("irq_hold", 32'(spi_irq), 1);
    tick();
    chk("irq_clr", 32'(spi_irq), 0);
    spi_done = 1'b1; wr(A_SPIE, 32'h1, 4'hF); spi_done = 1'b0;
    rd_chk("don_set_wins", A_SPIE, 32'h11);
    chk("irq_set_wins", 32'(spi_irq), 1);

    // Reset in the middle of traffic
    wr(A_SPMODE, 32'h1234, 4'hF);
    for (int i = 0; i < 3; i++) wr(A_SPITF, 32'h50 + 32'(i), 4'hF);
    rd_chk("tx_cnt3", A_SPFIFO, 32'h3);
    @(posedge clk); #3 rstn = 1'b0; #1;
    chk("mid_rst_rdata", spi_reg_data, 0);
    chk("mid_rst_spmode", spmode, 0);
    chk("mid_rst_txdata", tx_data, 0);
    chk("mid_rst_txvalid", 32'(tx_valid), 0);
    chk("mid_rst_irq", 32'(spi_irq), 0);
    @(posedge clk); #1 rstn = 1'b1;
    rd_chk("spfifo_after_rst", A_SPFIFO, 32'h0);

    // Randomized run against the reference model
    do_reset();
    m_spmode = 0; m_spim = 0; m_spcom = 0; m_rdata = 0;
    m_don = 0; m_rxovf = 0; m_txovf = 0;
    txq.delete(); rxq.delete();
    for (int c = 0; c < 3000; c++) begin
      wren = ($urandom_range(0, 2) == 0); awaddr = pick_addr();
      wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
      rden = ($urandom_range(0, 2) == 0); araddr = pick_addr();
      tx_ready = 1'($urandom_range(0, 1)); rx_valid = ($urandom_range(0, 3) == 0);
      rx_data = $urandom; spi_done = ($urandom_range(0, 15) == 0);

      irq_exp = |(m_spie() & m_spim);
      tx_pre = txq.size(); rx_pre = rxq.size();
      set_tx = 0; set_rx = 0;
      if (rden) begin
        if (araddr[11:8] != 4'h0) m_rdata = 0;
        else case (araddr[7:2])
          0: m_rdata = m_spmode;
          1: m_rdata = m_spie();
          2: m_rdata = m_spim;
          3: m_rdata = m_spcom;
          5: m_rdata = (rx_pre != 0) ? rxq.pop_front() : 32'h0;
          6: m_rdata = {16'h0, 8'(rx_pre), 8'(tx_pre)};
          default: m_rdata = 0;
        endcase
      end
      if (tx_ready && tx_pre != 0) void'(txq.pop_front());
      wr_pg = wren && (awaddr[11:8] == 4'h0);
      w = awaddr[7:2];
      if (wr_pg && w == 6'd4 && wstrb != 0) begin
        if (tx_pre == DEPTH) set_tx = 1; else txq.push_back(wdata);
      end
      if (rx_valid) begin
        if (rx_pre == DEPTH) set_rx = 1; else rxq.push_back(rx_data);
      end
      if (wr_pg && w == 6'd1) begin
        if (wdata[0]) m_don = 0;
        if (wdata[1]) m_rxovf = 0;
        if (wdata[2]) m_txovf = 0;
      end
      if (spi_done) m_don = 1;
      if (set_rx) m_rxovf = 1;
      if (set_tx) m_txovf = 1;
      if (wr_pg && w == 6'd0) m_spmode = merge(m_spmode, wdata, wstrb);
      if (wr_pg && w == 6'd2) m_spim = merge(m_spim, wdata, wstrb);
      if (wr_pg && w == 6'd3) m_spcom = merge(m_spcom, wdata, wstrb);

      tick();
      chk("rnd_rdata", spi_reg_data, m_rdata);
      chk("rnd_spmode", spmode, m_spmode);
      chk("rnd_spcom", spcom, m_spcom);
      chk("rnd_irq", 32'(spi_irq), 32'(irq_exp));
      chk("rnd_txvalid", 32'(tx_valid), 32'(txq.size() != 0));
      chk("rnd_txdata", tx_data, (txq.size() != 0) ? txq[0] : 32'h0);
    end
    wren = 1'b0; rden = 1'b0; rx_valid = 1'b0; spi_done = 1'b0; tx_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
